// File: rtl/multdiv_if.sv
// Handshake and data bundle between the execute stage and the sequential
// multiply/divide unit.
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             flush;
    logic             hiwrite;
    logic             lowrite;
    logic [WIDTH-1:0] hlin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srca, srcb, flush, hiwrite, lowrite, hlin,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, flush, hiwrite, lowrite, hlin,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/multdiv_seq.sv
// Bit-serial MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on entry; signs are re-applied in FIX.
module multdiv_seq #(
    parameter  int WIDTH = 32,
    localparam int CNTW  = $clog2(WIDTH) + 1
) (
    input logic      clk,
    input logic      reset,
    multdiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, dvd_q, dvd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic               dzero_q, dzero_d, ovf_q, ovf_d, done_q, done_d;

    logic signed [WIDTH-1:0] srca_s, srcb_s;
    logic                    sa, sb;
    logic [WIDTH:0]          sum, trial;
    logic [2*WIDTH:0]        shl;
    logic [2*WIDTH-1:0]      prod;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    assign srca_s = bus.srca;
    assign srcb_s = bus.srcb;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dzero_d = dzero_q;
        ovf_d   = ovf_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        sa      = ~bus.op[0] & (srca_s < 0);
        sb      = ~bus.op[0] & (srcb_s < 0);
        sum     = '0;
        trial   = '0;
        shl     = '0;
        prod    = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.hiwrite) hi_d = bus.hlin;
                if (bus.lowrite) lo_d = bus.hlin;
                if (bus.start && !bus.flush) begin
                    a_d     = neg_if(bus.srca, sa);
                    b_d     = neg_if(bus.srcb, sb);
                    div_d   = bus.op[1];
                    qneg_d  = sa ^ sb;
                    rneg_d  = sa;
                    dvd_d   = bus.srca;
                    dzero_d = (bus.srcb == '0);
                    ovf_d   = (bus.op == 2'b10) && (bus.srca == MOST_NEG) && (&bus.srcb);
                    // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                    acc_d   = {{WIDTH{1'b0}}, bus.op[1] ? neg_if(bus.srca, sa) : neg_if(bus.srcb, sb)};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!div_q) begin
                    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end else begin
                    shl   = {acc_q, 1'b0};
                    trial = shl[2*WIDTH:WIDTH] - {1'b0, b_q};
                    if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
                    else               acc_d = shl[2*WIDTH-1:0];
                end
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (!div_q) begin
                    prod = neg_if2(acc_q, qneg_q);
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (dzero_q) begin
                    hi_d = dvd_q;
                    lo_d = '1;
                end else if (ovf_q) begin
                    hi_d = '0;
                    lo_d = MOST_NEG;
                end else begin
                    hi_d = neg_if(acc_q[2*WIDTH-1:WIDTH], rneg_q);
                    lo_d = neg_if(acc_q[WIDTH-1:0], qneg_q);
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // An aborted op leaves HI/LO untouched, even in its final cycle.
        if (bus.flush && state_q != IDLE) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q   <= acc_d;
        a_q     <= a_d;
        b_q     <= b_d;
        dvd_q   <= dvd_d;
        div_q   <= div_d;
        qneg_q  <= qneg_d;
        rneg_q  <= rneg_d;
        dzero_q <= dzero_d;
        ovf_q   <= ovf_d;
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: arithmetic reference model plus cycle compare.
module tb_multdiv_seq;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    multdiv_if #(.WIDTH(WIDTH)) bus ();

    multdiv_seq #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_start = 0;
    bit chk_en = 1'b0;

    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} straight from the MIPS definitions.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        longint p;
        int q, r;
        logic [63:0] u;
        case (op)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            2'b01: begin
                u = {32'b0, a} * {32'b0, b};
                return u;
            end
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (bus.flush) m_busy <= 1'b0;
                else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                end else m_left <= m_left - 1;
            end else begin
                if (bus.hiwrite) m_hi <= bus.hlin;
                if (bus.lowrite) m_lo <= bus.hlin;
                if (bus.start && !bus.flush) begin
                    m_busy <= 1'b1;
                    m_left <= WIDTH + 1;
                    m_res  <= ref_result(bus.op, bus.srca, bus.srcb);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc.busy", {31'b0, bus.busy}, {31'b0, m_busy});
            chk("cyc.done", {31'b0, bus.done}, {31'b0, m_done});
            chk("cyc.hi", bus.hi, m_hi);
            chk("cyc.lo", bus.lo, m_lo);
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t_start   = cyc;
    endtask

    // Returns the done edge numbered from the start edge (start edge = 1).
    task automatic wait_done(input string name, output int lat, output int nbusy);
        bit seen = 1'b0;
        lat   = -1;
        nbusy = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                lat  = cyc - t_start + 1;
            end else if (bus.busy) nbusy++;
        end
        if (!seen) chk({name, ".timeout"}, 32'h0, 32'h1);
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat, nb;
        start_op(op, a, b);
        wait_done(name, lat, nb);
        chk({name, ".hi"}, bus.hi, ehi);
        chk({name, ".lo"}, bus.lo, elo);
        chk({name, ".lat"}, 32'(lat), 32'(WIDTH + 2));
        chk({name, ".busycyc"}, 32'(nb), 32'(WIDTH + 1));
    endtask

    task automatic count_done(input string name, input int n);
        int d = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) d++;
        end
        chk({name, ".nodone"}, 32'(d), 32'h0);
    endtask

    initial begin
        int lat, nb, d_first;
        bus.start = 0; bus.op = 0; bus.srca = 0; bus.srcb = 0;
        bus.flush = 0; bus.hiwrite = 0; bus.lowrite = 0; bus.hlin = 0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst.busy", {31'b0, bus.busy}, 32'h0);
        chk("rst.done", {31'b0, bus.done}, 32'h0);
        chk("rst.hi", bus.hi, 32'h0);
        chk("rst.lo", bus.lo, 32'h0);

        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        do_op("mult_m1m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
        do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu_7_2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
        do_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        do_op("div_m100_m7", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        do_op("divu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        do_op("div_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // Back-to-back: start presented during the done cycle.
        d_first = cyc;
        bus.start = 1'b1; bus.op = 2'b11; bus.srca = 32'd100; bus.srcb = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        t_start = cyc;
        wait_done("b2b", lat, nb);
        chk("b2b.gap", 32'(cyc - d_first), 32'(WIDTH + 2));
        chk("b2b.hi", bus.hi, 32'd2);
        chk("b2b.lo", bus.lo, 32'd14);

        // Preload via mthi/mtlo, then flush an op mid-flight.
        @(posedge clk);
        #1 bus.hiwrite = 1'b1; bus.hlin = 32'h11;
        @(posedge clk);
        #1 bus.hiwrite = 1'b0; bus.lowrite = 1'b1; bus.hlin = 32'h22;
        @(posedge clk);
        #1 bus.lowrite = 1'b0;
        @(negedge clk);
        chk("mt.hi", bus.hi, 32'h11);
        chk("mt.lo", bus.lo, 32'h22);
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush.busy", {31'b0, bus.busy}, 32'h0);
        chk("flush.hi", bus.hi, 32'h11);
        chk("flush.lo", bus.lo, 32'h22);
        count_done("flush", 40);

        // start and mthi while busy are both ignored.
        start_op(2'b01, 32'd3, 32'd5);
        repeat (4) @(posedge clk);
        #1 bus.start = 1'b1; bus.op = 2'b00; bus.srca = 32'hFFFF_FFFF; bus.srcb = 32'hFFFF_FFFF;
        bus.hiwrite = 1'b1; bus.hlin = 32'hDEAD;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.hiwrite = 1'b0;
        wait_done("ignore", lat, nb);
        chk("ignore.lat", 32'(lat), 32'(WIDTH + 2));
        chk("ignore.hi", bus.hi, 32'h0);
        chk("ignore.lo", bus.lo, 32'hF);
        count_done("ignore", 40);

        // Reset in the middle of an op.
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst.busy", {31'b0, bus.busy}, 32'h0);
        chk("midrst.done", {31'b0, bus.done}, 32'h0);
        chk("midrst.hi", bus.hi, 32'h0);
        chk("midrst.lo", bus.lo, 32'h0);
        count_done("midrst", 40);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
